// File: rtl/lcd_sink_if.sv
// HD44780 4-bit parallel bus bundle (enable strobe, register select, nibble).
// The master modport drives the bus (LCD driver side); the slave modport
// receives it (display model side).
//   lcd_en   : bus enable strobe, data is taken on its falling edge
//   lcd_rs   : register select, 0 = instruction, 1 = data
//   lcd_data : bus nibble
interface lcd_sink_if;
    logic       lcd_en;
    logic       lcd_rs;
    logic [3:0] lcd_data;

    modport master (output lcd_en, output lcd_rs, output lcd_data);
    modport slave  (input  lcd_en, input  lcd_rs, input  lcd_data);
endinterface

// File: rtl/lcd_sink.sv
// HD44780 display model: receiving end of the 4-bit parallel LCD bus.
// Decodes the 8-bit/4-bit power-up handshake, assembles nibbles into bytes,
// executes the instruction subset used by the driver and mirrors the 2x16
// DDRAM with a registered read port.
// Ports:
//   clk         : system clock
//   reset       : synchronous, active-low reset
//   bus         : lcd_sink_if slave (lcd_en, lcd_rs, lcd_data)
//   rd_addr     : DDRAM read index, bit4 = row, bits3:0 = column
//   rd_data     : DDRAM[rd_addr], one cycle after rd_addr
//   cmd_valid   : 1-cycle pulse when a byte is executed
//   cmd_rs      : rs of the executed byte
//   cmd_byte    : executed byte
//   mode_4bit   : interface is in 4-bit mode
//   display_on  : D bit of the last display control
//   two_line    : N bit of the last 4-bit function set
//   cursor_addr : current DDRAM address (0x00-0x0F or 0x40-0x4F)
//   busy        : DDRAM fill (reset or clear) in progress
//   proto_err   : 1-cycle pulse when a strobe arrives while busy
module lcd_sink #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_CHAR   = 8'h20
) (
    input  logic             clk,
    input  logic             reset,
    lcd_sink_if.slave        bus,
    input  logic [4:0]       rd_addr,
    output logic [7:0]       rd_data,
    output logic             cmd_valid,
    output logic             cmd_rs,
    output logic [7:0]       cmd_byte,
    output logic             mode_4bit,
    output logic             display_on,
    output logic             two_line,
    output logic [6:0]       cursor_addr,
    output logic             busy,
    output logic             proto_err
);

    typedef enum logic [1:0] {S_MODE8, S_MODE4_HI, S_MODE4_LO} state_t;

    // Cursor step with row wrap: 0x0F <-> 0x40 and 0x4F <-> 0x00.
    function automatic logic [6:0] f_cursor_step(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (inc) begin
            case (a)
                7'h0F:   n = 7'h40;
                7'h4F:   n = 7'h00;
                default: n = a + 7'd1;
            endcase
        end else begin
            case (a)
                7'h40:   n = 7'h0F;
                7'h00:   n = 7'h4F;
                default: n = a - 7'd1;
            endcase
        end
        return n;
    endfunction

    logic [5:0] w_bus_raw;
    logic [5:0] w_bus_s;
    assign w_bus_raw = {bus.lcd_en, bus.lcd_rs, bus.lcd_data};

    // Input synchronizer, en/rs/data travel together so they stay aligned.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_bus_s = w_bus_raw;
        end else begin : g_sync
            logic [5:0] r_sync [SYNC_STAGES];
            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
                end else begin
                    r_sync[0] <= w_bus_raw;
                    for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
                end
            end
            assign w_bus_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    logic       w_en, w_rs;
    logic [3:0] w_nib;
    assign w_en  = w_bus_s[5];
    assign w_rs  = w_bus_s[4];
    assign w_nib = w_bus_s[3:0];

    logic       r_en_q;
    logic       w_strobe, w_accept, w_exec, w_funcset;
    state_t     r_state, w_state_nxt;
    logic       w_complete, w_mode4;
    logic [7:0] w_byte;
    logic [3:0] r_hi;
    logic       r_busy;
    logic [4:0] r_clr_idx;
    logic       r_id;
    logic [6:0] r_cursor;
    logic       r_cmd_valid, r_cmd_rs, r_display_on, r_two_line, r_proto_err;
    logic [7:0] r_cmd_byte;
    logic [7:0] r_rd_data;
    logic [7:0] r_mem [32];

    // Strobes that land while busy are dropped without touching any state.
    assign w_strobe  = r_en_q & ~w_en;
    assign w_accept  = w_strobe & ~r_busy;
    assign w_exec    = w_accept & w_complete;
    assign w_funcset = ~w_rs & (w_byte[7:5] == 3'b001);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_en_q  <= 1'b0;
            r_state <= S_MODE8;
        end else begin
            r_en_q  <= w_en;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            case (r_state)
                S_MODE8:    if (w_funcset && !w_byte[4]) w_state_nxt = S_MODE4_HI;
                S_MODE4_HI: w_state_nxt = S_MODE4_LO;
                S_MODE4_LO: w_state_nxt = (w_funcset && w_byte[4]) ? S_MODE8 : S_MODE4_HI;
                default:    w_state_nxt = S_MODE8;
            endcase
        end
    end

    // In 8-bit mode the low nibble lines are not wired, so the byte is {data, 0}.
    always_comb begin
        w_complete = (r_state != S_MODE4_HI);
        w_mode4    = (r_state != S_MODE8);
        w_byte     = (r_state == S_MODE8) ? {w_nib, 4'h0} : {r_hi, w_nib};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi         <= 4'h0;
            r_busy       <= 1'b1;
            r_clr_idx    <= 5'd0;
            r_id         <= 1'b1;
            r_cursor     <= 7'h00;
            r_cmd_valid  <= 1'b0;
            r_cmd_rs     <= 1'b0;
            r_cmd_byte   <= 8'h00;
            r_display_on <= 1'b0;
            r_two_line   <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            r_cmd_valid <= w_exec;
            r_proto_err <= w_strobe & r_busy;
            if (w_accept && r_state == S_MODE4_HI) r_hi <= w_nib;
            if (r_busy) begin
                r_clr_idx <= r_clr_idx + 5'd1;
                if (r_clr_idx == 5'd31) r_busy <= 1'b0;
            end
            if (w_exec) begin
                r_cmd_rs   <= w_rs;
                r_cmd_byte <= w_byte;
                if (w_rs) begin
                    r_cursor <= f_cursor_step(r_cursor, r_id);
                end else if (w_byte[7]) begin
                    r_cursor <= {w_byte[6], 2'b00, w_byte[3:0]};
                end else if (w_byte[6]) begin
                    // CGRAM address: no CGRAM modelled
                end else if (w_byte[5]) begin
                    // N is only meaningful once the bus is really 4 bits wide
                    if (w_mode4) r_two_line <= w_byte[3];
                end else if (w_byte[4]) begin
                    // cursor/display shift: not modelled
                end else if (w_byte[3]) begin
                    r_display_on <= w_byte[2];
                end else if (w_byte[2]) begin
                    r_id <= w_byte[1];
                end else if (w_byte[1]) begin
                    r_cursor <= 7'h00;
                end else if (w_byte[0]) begin
                    r_cursor  <= 7'h00;
                    r_id      <= 1'b1;
                    r_busy    <= 1'b1;
                    r_clr_idx <= 5'd0;
                end
            end
        end
    end

    // Single DDRAM write port: fill while busy, data writes otherwise
    // (data cannot execute while busy, so the two never collide).
    logic       w_we;
    logic [4:0] w_waddr;
    logic [7:0] w_wdata;
    assign w_we    = r_busy | (w_exec & w_rs);
    assign w_waddr = r_busy ? r_clr_idx : {r_cursor[6], r_cursor[3:0]};
    assign w_wdata = r_busy ? FILL_CHAR : w_byte;

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    // Read-before-write: same-cycle write to the read cell returns old data.
    always_ff @(posedge clk) begin
        if (!reset) r_rd_data <= 8'h00;
        else        r_rd_data <= r_mem[rd_addr];
    end

    assign rd_data     = r_rd_data;
    assign cmd_valid   = r_cmd_valid;
    assign cmd_rs      = r_cmd_rs;
    assign cmd_byte    = r_cmd_byte;
    assign mode_4bit   = w_mode4;
    assign display_on  = r_display_on;
    assign two_line    = r_two_line;
    assign cursor_addr = r_cursor;
    assign busy        = r_busy;
    assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_lcd_sink.sv
// Directed bench for lcd_sink: drives the 4-bit LCD bus the way the driver
// does and checks the decoded state and DDRAM contents against hand values.
module tb_lcd_sink;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_data;
    logic       cmd_valid, cmd_rs;
    logic [7:0] cmd_byte;
    logic       mode_4bit, display_on, two_line, busy, proto_err;
    logic [6:0] cursor_addr;

    always #5 clk = ~clk;

    lcd_sink_if bus ();

    lcd_sink #(.SYNC_STAGES(2), .FILL_CHAR(8'h20)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_byte(cmd_byte),
        .mode_4bit(mode_4bit), .display_on(display_on), .two_line(two_line),
        .cursor_addr(cursor_addr), .busy(busy), .proto_err(proto_err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Event monitor, sampled on the falling edge.
    int         n_cmd = 0;
    int         n_perr = 0;
    int         n_busy = 0;
    logic       last_rs = 1'b0;
    logic [7:0] cmd_log [16];

    always @(negedge clk) begin
        if (cmd_valid) begin
            cmd_log[n_cmd[3:0]] <= cmd_byte;
            last_rs <= cmd_rs;
            n_cmd <= n_cmd + 1;
        end
        if (proto_err) n_perr <= n_perr + 1;
        if (busy)      n_busy <= n_busy + 1;
    end

    task automatic nib(input logic rs, input logic [3:0] d);
        @(posedge clk); #1;
        bus.lcd_rs = rs; bus.lcd_data = d; bus.lcd_en = 1'b1;
        @(posedge clk); #1;
        bus.lcd_en = 1'b0;
        repeat (6) @(posedge clk);
        #2;
    endtask

    task automatic byte4(input logic rs, input logic [7:0] b);
        nib(rs, b[7:4]);
        nib(rs, b[3:0]);
    endtask

    task automatic check_rd(input string tag, input logic [4:0] a, input logic [7:0] exp);
        @(posedge clk); #1;
        rd_addr = a;
        @(posedge clk); #1;
        check(tag, {24'h0, rd_data}, {24'h0, exp});
    endtask

    string s_msg = "Its Tapeout Time";
    int c0, p0, b0;

    initial begin
        bus.lcd_en = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_data = 4'h0;

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst_busy", busy, 1);
        check("rst_mode", mode_4bit, 0);
        check("rst_cmdv", cmd_valid, 0);
        check("rst_rd", rd_data, 0);
        check("rst_cursor", cursor_addr, 0);
        check("rst_disp", display_on, 0);
        check("rst_2line", two_line, 0);
        check("rst_perr", proto_err, 0);
        reset = 1'b1;
        repeat (31) @(posedge clk); #1;
        check("fill_busy31", busy, 1);
        @(posedge clk); #1;
        check("fill_busy32", busy, 0);
        for (int i = 0; i < 32; i++) check_rd("fill", 5'(i), 8'h20);

        // Power-up handshake 3,3,3,2
        c0 = n_cmd; p0 = n_perr;
        nib(0, 4'h3); check("init1_mode", mode_4bit, 0);
        nib(0, 4'h3);
        nib(0, 4'h3); check("init3_mode", mode_4bit, 0);
        nib(0, 4'h2); check("init4_mode", mode_4bit, 1);
        check("init_ncmd", n_cmd - c0, 4);
        check("init_b0", cmd_log[(c0 + 0) % 16], 8'h30);
        check("init_b1", cmd_log[(c0 + 1) % 16], 8'h30);
        check("init_b2", cmd_log[(c0 + 2) % 16], 8'h30);
        check("init_b3", cmd_log[(c0 + 3) % 16], 8'h20);
        check("init_perr", n_perr - p0, 0);

        // Configuration
        byte4(0, 8'h28); check("fs_2line", two_line, 1); check("fs_mode", mode_4bit, 1);
        byte4(0, 8'h0C); check("dc_on", display_on, 1);
        byte4(0, 8'h06);
        b0 = n_busy;
        byte4(0, 8'h01);
        repeat (40) @(posedge clk); #1;
        check("clr_cycles", n_busy - b0, 32);
        check("clr_busy", busy, 0);
        check("clr_cursor", cursor_addr, 0);
        check("clr_last", cmd_log[(n_cmd - 1) % 16], 8'h01);

        // Text on row 0
        for (int i = 0; i < 16; i++) byte4(1, s_msg[i]);
        check("txt_cursor", cursor_addr, 7'h40);
        check("txt_rs", last_rs, 1);
        for (int i = 0; i < 16; i++) check_rd("txt", 5'(i), s_msg[i]);

        // Set DDRAM into row 1
        byte4(0, 8'hC4); check("sd_cursor", cursor_addr, 7'h44);
        byte4(1, 8'h31); byte4(1, 8'h32);
        check("r1_cursor", cursor_addr, 7'h46);
        check_rd("r1_c4", 5'h14, 8'h31);
        check_rd("r1_c5", 5'h15, 8'h32);

        // Row wrap, increment and decrement
        byte4(0, 8'h8F); check("wrap_set", cursor_addr, 7'h0F);
        byte4(1, 8'h41); check("wrap_inc", cursor_addr, 7'h40);
        check_rd("wrap_A", 5'h0F, 8'h41);
        byte4(0, 8'h04);
        byte4(0, 8'h80); check("home_set", cursor_addr, 7'h00);
        byte4(1, 8'h42); check("wrap_dec", cursor_addr, 7'h4F);
        check_rd("dec_B", 5'h00, 8'h42);
        check_rd("dec_keep", 5'h01, 8'h74);
        byte4(1, 8'h43); check("dec_step", cursor_addr, 7'h4E);
        check_rd("dec_C", 5'h1F, 8'h43);

        // Strobes during clear are dropped
        c0 = n_cmd; p0 = n_perr;
        byte4(0, 8'h01);
        byte4(1, 8'h5A);
        check("drop_perr", n_perr - p0, 2);
        check("drop_ncmd", n_cmd - c0, 1);
        repeat (40) @(posedge clk); #1;
        check("drop_busy", busy, 0);
        check("drop_cursor", cursor_addr, 0);
        check_rd("drop_c0", 5'h00, 8'h20);
        check_rd("drop_c14", 5'h14, 8'h20);

        // Reset between the two nibbles of a byte
        nib(1, 4'h4);
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("mrst_mode", mode_4bit, 0);
        check("mrst_busy", busy, 1);
        check("mrst_2line", two_line, 0);
        reset = 1'b1;
        repeat (34) @(posedge clk); #1;
        check("mrst_fill", busy, 0);
        c0 = n_cmd;
        nib(0, 4'h2);
        check("mrst_ncmd", n_cmd - c0, 1);
        check("mrst_byte", cmd_log[c0 % 16], 8'h20);
        check("mrst_rs", last_rs, 0);
        check("mrst_mode4", mode_4bit, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
